// File: rtl/lcd_bus_responder.sv
// Clocked responder for an 8-bit HD44780-style LCD bus: keeps the DDRAM image,
// cursor and display flags, answers bus reads and offers a mirror read port.
module lcd_bus_responder #(
    parameter int BUSY_CYCLES  = 40,
    parameter int CLEAR_CYCLES = 1600
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       lcd_en,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic [6:0] cursor_addr,
    output logic       busy,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       cmd_err
);
    localparam int CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, BUSY, CLEAR} state_t;

    state_t           state;
    logic [7:0]       mem [0:79];
    logic [CNT_W-1:0] cnt;
    logic [6:0]       fill_idx;
    logic             inc_mode;
    logic             en_s1, en_s2, en_d;
    logic             rs_s1, rs_s2, rw_s1, rw_s2;
    logic [7:0]       db_s1, db_s2;
    logic             commit;

    function automatic logic addr_valid(input logic [6:0] a);
        return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
    endfunction

    // Line 2 (0x40-0x67) packs directly after line 1 at index 40-79.
    function automatic logic [6:0] addr_idx(input logic [6:0] a);
        return (a >= 7'h40) ? (a - 7'd24) : a;
    endfunction

    function automatic logic [6:0] addr_step(input logic [6:0] a, input logic up);
        if (up)
            return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
        else
            return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
    endfunction

    assign commit = en_d & ~en_s2;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int unsigned i = 0; i < 80; i++) mem[i] <= 8'h20;
            state        <= IDLE;
            cnt          <= '0;
            fill_idx     <= '0;
            inc_mode     <= 1'b1;
            {en_s1, en_s2, en_d} <= '0;
            {rs_s1, rs_s2, rw_s1, rw_s2} <= '0;
            db_s1        <= '0;
            db_s2        <= '0;
            lcd_data_out <= '0;
            lcd_data_oe  <= 1'b0;
            disp_on      <= 1'b0;
            cursor_on    <= 1'b0;
            blink_on     <= 1'b0;
            cursor_addr  <= '0;
            busy         <= 1'b0;
            rd_data      <= '0;
            cmd_err      <= 1'b0;
        end else begin
            en_s1 <= lcd_en;
            en_s2 <= en_s1;
            en_d  <= en_s2;
            rs_s1 <= lcd_rs;
            rs_s2 <= rs_s1;
            rw_s1 <= lcd_rw;
            rw_s2 <= rw_s1;
            db_s1 <= lcd_data_in;
            db_s2 <= db_s1;
            cmd_err <= 1'b0;

            lcd_data_oe <= en_s2 & rw_s2;
            if (en_s2 && rw_s2)
                lcd_data_out <= rs_s2 ? mem[addr_idx(cursor_addr)] : {busy, cursor_addr};

            rd_data <= addr_valid(rd_addr) ? mem[addr_idx(rd_addr)] : 8'h20;

            if (state == CLEAR) begin
                mem[fill_idx] <= 8'h20;
                fill_idx      <= fill_idx + 7'd1;
                if (fill_idx == 7'd79) state <= BUSY;
            end

            // Counter expiry is evaluated last so it wins over the CLEAR->BUSY step.
            if (busy) begin
                if (cnt <= CNT_W'(1)) begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end

            if (commit) begin
                if (rw_s2) begin
                    if (rs_s2) begin
                        cursor_addr <= addr_step(cursor_addr, inc_mode);
                        if (busy) cmd_err <= 1'b1;
                    end
                end else if (busy) begin
                    cmd_err <= 1'b1;
                end else begin
                    busy  <= 1'b1;
                    state <= BUSY;
                    cnt   <= CNT_W'(BUSY_CYCLES);
                    if (rs_s2) begin
                        mem[addr_idx(cursor_addr)] <= db_s2;
                        cursor_addr <= addr_step(cursor_addr, inc_mode);
                    end else begin
                        casez (db_s2)
                            8'b1???????: begin
                                if (addr_valid(db_s2[6:0])) begin
                                    cursor_addr <= db_s2[6:0];
                                end else begin
                                    cursor_addr <= '0;
                                    cmd_err     <= 1'b1;
                                end
                            end
                            8'b01??????: cmd_err <= 1'b1;
                            8'b001?????: if (!db_s2[4]) cmd_err <= 1'b1;
                            8'b0001????: if (!db_s2[3]) cursor_addr <= addr_step(cursor_addr, db_s2[2]);
                            8'b00001???: begin
                                disp_on   <= db_s2[2];
                                cursor_on <= db_s2[1];
                                blink_on  <= db_s2[0];
                            end
                            8'b000001??: inc_mode <= db_s2[1];
                            8'b0000001?: begin
                                cursor_addr <= '0;
                                cnt         <= CNT_W'(CLEAR_CYCLES);
                            end
                            8'b00000001: begin
                                state       <= CLEAR;
                                fill_idx    <= '0;
                                cursor_addr <= '0;
                                inc_mode    <= 1'b1;
                                cnt         <= CNT_W'(CLEAR_CYCLES);
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder: drives LCD bus cycles and checks
// flags, cursor, busy length, cmd_err pulses and the mirror port.
module tb_lcd_bus_responder;
    logic       clk_clk = 1'b0;
    logic       reset_reset = 1'b1;
    logic       lcd_en = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
    logic [7:0] lcd_data_in = 8'h00;
    logic [6:0] rd_addr = 7'h00;
    logic [7:0] lcd_data_out, rd_data;
    logic       lcd_data_oe, disp_on, cursor_on, blink_on, busy, cmd_err;
    logic [6:0] cursor_addr;

    int pass_cnt = 0, total_cnt = 0, busy_hi = 0, err_cnt = 0;

    lcd_bus_responder #(.BUSY_CYCLES(40), .CLEAR_CYCLES(1600)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
        .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .cursor_addr(cursor_addr), .busy(busy),
        .rd_addr(rd_addr), .rd_data(rd_data), .cmd_err(cmd_err)
    );

    always #5 clk_clk = ~clk_clk;

    always @(negedge clk_clk) begin
        if (busy === 1'b1) busy_hi++;
        if (cmd_err === 1'b1) err_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic bus_write(input logic rs, input logic [7:0] d);
        @(negedge clk_clk);
        lcd_rs = rs; lcd_rw = 1'b0; lcd_data_in = d; lcd_en = 1'b1;
        repeat (4) @(negedge clk_clk);
        lcd_en = 1'b0;
    endtask

    task automatic bus_read(input logic rs, output logic [7:0] d, output logic oe_hi, output logic oe_after);
        @(negedge clk_clk);
        lcd_rs = rs; lcd_rw = 1'b1; lcd_en = 1'b1;
        repeat (4) @(negedge clk_clk);
        d = lcd_data_out; oe_hi = lcd_data_oe;
        lcd_en = 1'b0;
        repeat (4) @(negedge clk_clk);
        oe_after = lcd_data_oe;
    endtask

    task automatic mirror(input logic [6:0] a, output logic [7:0] d);
        @(negedge clk_clk);
        rd_addr = a;
        @(negedge clk_clk);
        d = rd_data;
    endtask

    task automatic wait_done(input int b0, input string name);
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk_clk); #1;
            if (busy_hi != b0 && busy == 1'b0) done = 1;
        end
        total_cnt++;
        if (!done) $display("FAIL %s: busy cycle did not complete, busy=%b", name, busy); else pass_cnt++;
    endtask

    task automatic wait_busy(input string name);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_clk);
            if (busy === 1'b1) seen = 1;
        end
        total_cnt++;
        if (!seen) $display("FAIL %s: busy never rose", name); else pass_cnt++;
    endtask

    task automatic write_op(input logic rs, input logic [7:0] d, input string name);
        int b0;
        b0 = busy_hi;
        bus_write(rs, d);
        wait_done(b0, name);
    endtask

    task automatic test_reset();
        logic [7:0] d; logic oh, oa;
        reset_reset = 1'b1;
        repeat (3) @(negedge clk_clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if ({disp_on, cursor_on, blink_on} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {disp_on, cursor_on, blink_on}); else pass_cnt++;
        total_cnt++; if (cursor_addr !== 7'h00) $display("FAIL rst_cursor: got %h want 00", cursor_addr); else pass_cnt++;
        total_cnt++; if ({lcd_data_oe, lcd_data_out} !== 9'h000) $display("FAIL rst_bus: got %h want 000", {lcd_data_oe, lcd_data_out}); else pass_cnt++;
        total_cnt++; if ({cmd_err, rd_data} !== 9'h000) $display("FAIL rst_err_rd: got %h want 000", {cmd_err, rd_data}); else pass_cnt++;
        @(negedge clk_clk);
        reset_reset = 1'b0;
        bus_read(1'b0, d, oh, oa);
        total_cnt++; if (d !== 8'h00) $display("FAIL rst_instr_read: got %h want 00", d); else pass_cnt++;
        total_cnt++; if (oh !== 1'b1) $display("FAIL rst_oe_high: got %b want 1", oh); else pass_cnt++;
        total_cnt++; if (oa !== 1'b0) $display("FAIL rst_oe_drop: got %b want 0", oa); else pass_cnt++;
        mirror(7'h10, d);
        total_cnt++; if (d !== 8'h20) $display("FAIL rst_ddram: got %h want 20", d); else pass_cnt++;
    endtask

    task automatic test_write_data();
        int b0; logic [7:0] d; logic oh, oa;
        b0 = busy_hi; bus_write(1'b0, 8'h0F); wait_done(b0, "disp_ctl_done");
        total_cnt++; if (busy_hi - b0 != 40) $display("FAIL busy_len_0F: got %0d want 40", busy_hi - b0); else pass_cnt++;
        total_cnt++; if ({disp_on, cursor_on, blink_on} !== 3'b111) $display("FAIL flags_0F: got %b want 111", {disp_on, cursor_on, blink_on}); else pass_cnt++;
        b0 = busy_hi; bus_write(1'b1, 8'h41); wait_done(b0, "data41_done");
        total_cnt++; if (busy_hi - b0 != 40) $display("FAIL busy_len_41: got %0d want 40", busy_hi - b0); else pass_cnt++;
        b0 = busy_hi; bus_write(1'b1, 8'h42); wait_done(b0, "data42_done");
        total_cnt++; if (busy_hi - b0 != 40) $display("FAIL busy_len_42: got %0d want 40", busy_hi - b0); else pass_cnt++;
        mirror(7'h00, d);
        total_cnt++; if (d !== 8'h41) $display("FAIL mirror_00: got %h want 41", d); else pass_cnt++;
        mirror(7'h01, d);
        total_cnt++; if (d !== 8'h42) $display("FAIL mirror_01: got %h want 42", d); else pass_cnt++;
        total_cnt++; if (cursor_addr !== 7'h02) $display("FAIL cursor_after_data: got %h want 02", cursor_addr); else pass_cnt++;
        write_op(1'b0, 8'h80, "set_ddram_00");
        bus_read(1'b1, d, oh, oa);
        total_cnt++; if (d !== 8'h41) $display("FAIL data_read: got %h want 41", d); else pass_cnt++;
        total_cnt++; if (cursor_addr !== 7'h01) $display("FAIL cursor_after_read: got %h want 01", cursor_addr); else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        write_op(1'b0, 8'hA7, "set_ddram_27");
        total_cnt++; if (cursor_addr !== 7'h27) $display("FAIL cursor_set_27: got %h want 27", cursor_addr); else pass_cnt++;
        write_op(1'b1, 8'h5A, "data5A");
        total_cnt++; if (cursor_addr !== 7'h40) $display("FAIL wrap_27_40: got %h want 40", cursor_addr); else pass_cnt++;
        mirror(7'h27, d);
        total_cnt++; if (d !== 8'h5A) $display("FAIL mirror_27: got %h want 5a", d); else pass_cnt++;
        write_op(1'b0, 8'h04, "entry_dec");
        write_op(1'b0, 8'h80, "set_ddram_00b");
        write_op(1'b1, 8'h33, "data33");
        total_cnt++; if (cursor_addr !== 7'h67) $display("FAIL wrap_00_67: got %h want 67", cursor_addr); else pass_cnt++;
        mirror(7'h00, d);
        total_cnt++; if (d !== 8'h33) $display("FAIL mirror_00_dec: got %h want 33", d); else pass_cnt++;
        write_op(1'b0, 8'h06, "entry_inc");
    endtask

    task automatic test_busy_violation();
        int b0, e0; logic [7:0] d;
        write_op(1'b0, 8'h85, "set_ddram_05");
        b0 = busy_hi; e0 = err_cnt;
        bus_write(1'b1, 8'h55);
        wait_busy("viol_busy_rise");
        bus_write(1'b1, 8'hEE);
        wait_done(b0, "viol_done");
        total_cnt++; if (busy_hi - b0 != 40) $display("FAIL viol_busy_len: got %0d want 40", busy_hi - b0); else pass_cnt++;
        total_cnt++; if (err_cnt - e0 != 1) $display("FAIL viol_err_pulses: got %0d want 1", err_cnt - e0); else pass_cnt++;
        mirror(7'h05, d);
        total_cnt++; if (d !== 8'h55) $display("FAIL viol_mem05: got %h want 55", d); else pass_cnt++;
        mirror(7'h06, d);
        total_cnt++; if (d !== 8'h20) $display("FAIL viol_mem06: got %h want 20", d); else pass_cnt++;
        total_cnt++; if (cursor_addr !== 7'h06) $display("FAIL viol_cursor: got %h want 06", cursor_addr); else pass_cnt++;
    endtask

    task automatic test_invalid();
        int e0; logic [7:0] d;
        e0 = err_cnt;
        write_op(1'b0, 8'hB0, "set_ddram_invalid");
        total_cnt++; if (cursor_addr !== 7'h00) $display("FAIL invalid_cursor: got %h want 00", cursor_addr); else pass_cnt++;
        total_cnt++; if (err_cnt - e0 != 1) $display("FAIL invalid_err: got %0d want 1", err_cnt - e0); else pass_cnt++;
        mirror(7'h30, d);
        total_cnt++; if (d !== 8'h20) $display("FAIL mirror_invalid: got %h want 20", d); else pass_cnt++;
        e0 = err_cnt;
        write_op(1'b0, 8'h28, "fset_4bit");
        total_cnt++; if (err_cnt - e0 != 1) $display("FAIL fset_4bit_err: got %0d want 1", err_cnt - e0); else pass_cnt++;
        e0 = err_cnt;
        write_op(1'b0, 8'h38, "fset_8bit");
        total_cnt++; if (err_cnt - e0 != 0) $display("FAIL fset_8bit_err: got %0d want 0", err_cnt - e0); else pass_cnt++;
        e0 = err_cnt;
        write_op(1'b0, 8'h40, "cgram");
        total_cnt++; if (err_cnt - e0 != 1) $display("FAIL cgram_err: got %0d want 1", err_cnt - e0); else pass_cnt++;
    endtask

    task automatic test_clear();
        int b0; logic [7:0] d; logic oh, oa; logic [6:0] a;
        write_op(1'b0, 8'h8A, "set_ddram_0a");
        b0 = busy_hi;
        bus_write(1'b0, 8'h01);
        wait_busy("clear_busy_rise");
        repeat (100) @(negedge clk_clk);
        bus_read(1'b0, d, oh, oa);
        total_cnt++; if (d !== 8'h80) $display("FAIL clear_instr_read: got %h want 80", d); else pass_cnt++;
        wait_done(b0, "clear_done");
        total_cnt++; if (busy_hi - b0 != 1600) $display("FAIL clear_busy_len: got %0d want 1600", busy_hi - b0); else pass_cnt++;
        total_cnt++; if (cursor_addr !== 7'h00) $display("FAIL clear_cursor: got %h want 00", cursor_addr); else pass_cnt++;
        for (int i = 0; i < 80; i++) begin
            a = (i < 40) ? 7'(i) : 7'(i + 24);
            mirror(a, d);
            total_cnt++; if (d !== 8'h20) $display("FAIL clear_fill_%h: got %h want 20", a, d); else pass_cnt++;
        end
        write_op(1'b1, 8'h11, "post_clear_data");
        total_cnt++; if (cursor_addr !== 7'h01) $display("FAIL clear_id_inc: got %h want 01", cursor_addr); else pass_cnt++;
    endtask

    task automatic test_reset_during_clear();
        logic [7:0] d;
        write_op(1'b0, 8'hE7, "set_ddram_67");
        write_op(1'b1, 8'h77, "data77");
        mirror(7'h67, d);
        total_cnt++; if (d !== 8'h77) $display("FAIL mem67_written: got %h want 77", d); else pass_cnt++;
        bus_write(1'b0, 8'h01);
        wait_busy("clear2_busy_rise");
        repeat (20) @(negedge clk_clk);
        #2 reset_reset = 1'b1;
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rstclr_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (disp_on !== 1'b0) $display("FAIL rstclr_disp: got %b want 0", disp_on); else pass_cnt++;
        @(negedge clk_clk);
        reset_reset = 1'b0;
        mirror(7'h67, d);
        total_cnt++; if (d !== 8'h20) $display("FAIL rstclr_mem67: got %h want 20", d); else pass_cnt++;
        mirror(7'h00, d);
        total_cnt++; if (d !== 8'h20) $display("FAIL rstclr_mem00: got %h want 20", d); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write_data();
        test_wrap();
        test_busy_violation();
        test_invalid();
        test_clear();
        test_reset_during_clear();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/lcd_bus_responder.md
Name: lcd_bus_responder

Overview:
- Clocked responder for the 8-bit HD44780-style LCD bus (E, RS, RW, DB[7:0]) that the processor system drives.
- Decodes the instruction and data cycles and keeps an 80-byte DDRAM image, cursor address and display-control flags.
- Answers busy-flag and data reads on the bus.
- Lets VGA text overlay logic and verification read back the panel contents without a physical LCD.

Parameters:
- BUSY_CYCLES, 40: clk_clk cycles busy stays high after any non-clear instruction or data write.
- CLEAR_CYCLES, 1600: clk_clk cycles busy stays high after Clear Display or Return Home. Must be >= 80.

Ports:
- clk_clk, input, 1: system clock.
- reset_reset, input, 1: asynchronous, active-high reset.
- lcd_en, input, 1: LCD E strobe, asynchronous to clk_clk.
- lcd_rs, input, 1: 0 = instruction, 1 = data.
- lcd_rw, input, 1: 0 = write, 1 = read.
- lcd_data_in, input, 8: DB[7:0] from the master.
- lcd_data_out, output, 8: DB[7:0] returned on reads.
- lcd_data_oe, output, 1: high while the responder drives DB.
- disp_on, output, 1: display-on flag (D).
- cursor_on, output, 1: cursor-visible flag (C).
- blink_on, output, 1: cursor-blink flag (B).
- cursor_addr, output, 7: current DDRAM address in HD44780 coding.
- busy, output, 1: busy flag.
- rd_addr, input, 7: mirror read address in HD44780 coding.
- rd_data, output, 8: mirror read data, 1-cycle latency.
- cmd_err, output, 1: one-cycle pulse on a protocol violation.

Behaviour:
- Reset values: DDRAM all 0x20, cursor_addr 0x00, I/D 1, busy 0, disp_on/cursor_on/blink_on 0, lcd_data_oe 0, lcd_data_out 0x00, cmd_err 0, rd_data 0x00.
- Async reset mid-operation aborts clear fill and busy count immediately.
- Input sync:
  - lcd_en, lcd_rs, lcd_rw and lcd_data_in pass through 2-flop synchronizers.
  - A falling edge of synchronized E is the commit strobe. The commit acts on the synced RS/RW/DB.
  - Commit is 3 clocks after the pin E falls. The master must hold RS/RW/DB stable for >= 3 clocks around the E fall.
- Address space:
  - Valid addresses are 0x00-0x27 (line 1) and 0x40-0x67 (line 2), stored at index 0-79.
  - Increment wraps 0x27->0x40 and 0x67->0x00.
  - Decrement wraps 0x00->0x67 and 0x40->0x27.
- Writes (RW=0) at commit. Busy is asserted the same cycle; the counter loads BUSY_CYCLES unless stated otherwise.
  - RS=1: DDRAM[cursor] <= DB, then cursor moves by I/D (1 = increment).
  - 0x01 Clear: state CLEAR.
    - Fill index 0..79 with 0x20, one per clock, for 80 clocks.
    - cursor <= 0x00, I/D <= 1.
    - Busy counter loads CLEAR_CYCLES and runs concurrently with the fill.
  - 0x02/0x03 Return Home: cursor <= 0x00, counter loads CLEAR_CYCLES.
  - 0x04-0x07 Entry Mode: I/D <= DB[1]. The S bit is ignored.
  - 0x08-0x0F Display Control: disp_on <= DB[2], cursor_on <= DB[1], blink_on <= DB[0].
  - 0x10-0x1F Shift:
    - If DB[3]=0, the cursor moves right when DB[2]=1 and left when DB[2]=0.
    - If DB[3]=1 (display shift), no action.
  - 0x20-0x3F Function Set: accepted. If DB[4]=0 (4-bit mode), pulse cmd_err.
  - 0x40-0x7F Set CGRAM address: ignored and pulses cmd_err. Busy is still asserted.
  - 0x80-0xFF Set DDRAM address: cursor <= DB[6:0] if valid; otherwise cursor <= 0x00 and cmd_err pulses.
- Busy handling:
  - Busy deasserts when the counter reaches 0.
  - Any write commit while busy=1 is ignored, pulses cmd_err, and does not restart the counter.
- States: IDLE, BUSY, CLEAR.
  - CLEAR goes to BUSY after the 80th fill.
  - BUSY goes to IDLE when the counter reaches 0.
- Reads (RW=1):
  - While synced E=1 and RW=1, lcd_data_oe=1. It drops on the first clock after synced E falls.
  - RS=0: lcd_data_out = {busy, cursor_addr}. This is always allowed, even while busy.
  - RS=1: lcd_data_out = DDRAM[cursor]. At the E-fall commit the cursor advances by I/D with no busy assertion. A data read while busy returns the data and pulses cmd_err.
- Mirror port:
  - rd_data = DDRAM[rd_addr], registered, valid 1 clock after rd_addr.
  - An invalid rd_addr returns 0x20.
  - On a same-cycle bus write to the same address, the mirror returns the old data.

Test Plan:
- Reset, then read instruction (RS=0, RW=1) -> lcd_data_out 0x00, lcd_data_oe 1 while E high, busy 0.
- Write 0x0F, then data 0x41 0x42 -> disp/cursor/blink all 1; rd_addr 0x00/0x01 give 0x41/0x42; cursor_addr 0x02; busy high for 40 clocks after each commit.
- Set DDRAM 0xA7 (addr 0x27), write 0x5A -> cursor_addr 0x40. Entry 0x04, then a data write at 0x00 -> cursor_addr 0x67.
- Issue a write 10 clocks after a data commit -> write ignored, cmd_err pulses once, busy count unchanged.
- Clear 0x01 after filling data -> all 80 locations read 0x20, cursor 0x00, busy high for 1600 clocks, instruction read returns 0x80 mid-busy.
- Set DDRAM 0xB0 (invalid) -> cursor 0x00, cmd_err pulse. Assert reset during clear -> busy 0 and DDRAM all 0x20 at once.
